// File: rtl/csa_resolver_if.sv
// Handshake bundle for csa_resolver: operand pair in, resolved sum out.
// The sticky signal exists only when CPA_STICKY_EN is defined.
interface csa_resolver_if #(
    parameter int unsigned WIDTH = 51
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] carry_in;
    logic [WIDTH-1:0] sum_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef CPA_STICKY_EN
    logic             sticky;

    modport master (
        output in_valid, carry_in, sum_in, out_ready,
        input  in_ready, out_valid, result, cout, sticky
    );
    modport slave (
        input  in_valid, carry_in, sum_in, out_ready,
        output in_ready, out_valid, result, cout, sticky
    );
`else
    modport master (
        output in_valid, carry_in, sum_in, out_ready,
        input  in_ready, out_valid, result, cout
    );
    modport slave (
        input  in_valid, carry_in, sum_in, out_ready,
        output in_ready, out_valid, result, cout
    );
`endif
endinterface

// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate adder resolving a carry-save pair CHUNK bits per clock.
// Optional feature macro CPA_STICKY_EN adds a sticky OR over the low STICKY_BITS result bits.
module csa_resolver #(
    parameter int unsigned WIDTH = 51,
    parameter int unsigned CHUNK = 17
`ifdef CPA_STICKY_EN
    ,
    parameter int unsigned STICKY_BITS = 25
`endif
) (
    input logic           clk,
    input logic           rst,
    csa_resolver_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic             cout_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;

    // Constant-base chunk mux keeps every part-select static.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    end

`ifdef CPA_STICKY_EN
    logic sticky_q;
    logic chunk_sticky;

    // Only the bits of this chunk that fall below STICKY_BITS contribute.
    always_comb begin
        chunk_sticky = 1'b0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if ((32'(idx_q) * CHUNK + i) < STICKY_BITS) begin
                chunk_sticky = chunk_sticky | chunk_sum[i];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
`ifdef CPA_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.carry_in;
                        b_q      <= bus.sum_in;
                        carry_q  <= 1'b0;
                        idx_q    <= '0;
`ifdef CPA_STICKY_EN
                        sticky_q <= 1'b0;
`endif
                        state_q  <= StAdd;
                    end
                end
                StAdd: begin
                    for (int unsigned k = 0; k < NCHUNK; k++) begin
                        if (idx_q == IDXW'(k)) begin
                            result_q[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                        end
                    end
                    carry_q <= chunk_sum[CHUNK];
`ifdef CPA_STICKY_EN
                    sticky_q <= sticky_q | chunk_sticky;
`endif
                    if (idx_q == IDXW'(NCHUNK - 1)) begin
                        cout_q  <= chunk_sum[CHUNK];
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
`ifdef CPA_STICKY_EN
    assign bus.sticky    = sticky_q;
`endif
endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: directed corner cases plus random operand pairs
// compared against a whole-word arithmetic reference.
module tb_csa_resolver;
    localparam int unsigned WIDTH = 51;
    localparam int unsigned STICKY_BITS = 25;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    csa_resolver_if #(.WIDTH(WIDTH)) bus ();

    csa_resolver #(.WIDTH(WIDTH), .CHUNK(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] s);
        return {1'b0, c} + {1'b0, s};
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[WIDTH-1:0];
    endfunction

    task automatic run_op(input string tag, input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] s,
                          input int hold, input bit pulse);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] exp_res;
        int               budget;
        full    = ref_add(c, s);
        exp_res = full[WIDTH-1:0];
        budget  = 0;
        while (bus.in_ready !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        if (budget >= 20) check({tag, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
        bus.carry_in = c;
        bus.sum_in   = s;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        step();
        step();
        check({tag, "_lat2"}, 64'(bus.out_valid), 64'd0);
        step();
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        check({tag, "_cout"}, 64'(bus.cout), 64'(full[WIDTH]));
`ifdef CPA_STICKY_EN
        check({tag, "_sticky"}, 64'(bus.sticky), 64'(|exp_res[STICKY_BITS-1:0]));
`endif
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                bus.in_valid = i[0];
                bus.carry_in = rnd_word();
                bus.sum_in   = rnd_word();
            end
            step();
            check({tag, "_hold_result"}, 64'(bus.result), 64'(exp_res));
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
        end
        // in_valid high on the release edge must not be taken as an accept.
        bus.in_valid  = pulse;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.carry_in  = '0;
        bus.sum_in    = '0;
        step();
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
`ifdef CPA_STICKY_EN
        check("rst_sticky", 64'(bus.sticky), 64'd0);
`endif
        // Reset outranks a pending operand.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        check("rst_prio", 64'(bus.in_ready), 64'd1);

        run_op("small", 51'h0, 51'h5, 0, 1'b0);
        run_op("ripple", 51'h1, 51'h7FFFFFFFFFFFF, 0, 1'b0);
        run_op("cross01", 51'h10000, 51'h10000, 0, 1'b0);
        run_op("stall", 51'h123456789ABC, 51'h0FEDCBA98765, 5, 1'b1);

        // Abort mid-add with chunk index 1 in flight.
        bus.carry_in = 51'h7FFFFFFFFFFFF;
        bus.sum_in   = 51'h7FFFFFFFFFFFF;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_state", 64'(bus.in_ready), 64'd1);
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_cout", 64'(bus.cout), 64'd0);
        step();
        step();
        step();
        check("abort_no_emit", 64'(bus.out_valid), 64'd0);

`ifdef CPA_STICKY_EN
        run_op("sticky_low", 51'h0, 51'h8, 0, 1'b0);
        run_op("sticky_high", 51'h0, 51'h2000000, 0, 1'b0);
        run_op("sticky_edge", 51'h0, 51'h1000000, 0, 1'b0);
`endif

        for (int n = 0; n < 20; n++) begin
            run_op("rand", rnd_word(), rnd_word(), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
